// File: rtl/iob_uart_console_ctrl_pkg.sv
// Shared definitions for the UART console controller: FSM state encoding,
// byte-strobe constants and the default iob_uart register map.
package iob_uart_console_ctrl_pkg;

    typedef enum logic [3:0] {
        S_SRST = 4'd0,
        S_SCLR = 4'd1,
        S_DIV  = 4'd2,
        S_TXEN = 4'd3,
        S_RXEN = 4'd4,
        S_IDLE = 4'd5,
        S_PRX  = 4'd6,
        S_RRX  = 4'd7,
        S_PTX  = 4'd8,
        S_WTX  = 4'd9
    } state_t;

    localparam logic [3:0] WSTRB_RD = 4'b0000;
    localparam logic [3:0] WSTRB_B0 = 4'b0001;
    localparam logic [3:0] WSTRB_H0 = 4'b0011;

    localparam int A_SOFTRST_DEF = 0;
    localparam int A_DIV_DEF     = 1;
    localparam int A_TXDATA_DEF  = 2;
    localparam int A_TXEN_DEF    = 3;
    localparam int A_TXREADY_DEF = 4;
    localparam int A_RXDATA_DEF  = 5;
    localparam int A_RXEN_DEF    = 6;
    localparam int A_RXREADY_DEF = 7;

endpackage

// File: rtl/iob_uart_console_ctrl_fifo.sv
// Small synchronous FIFO used for the console RX and TX byte queues.
// Push when full and pop when empty are ignored; DEPTH must be a power of 2.
module iob_uart_console_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]                 cnt_q, cnt_d;
    logic [DEPTH-1:0][W-1:0]     mem_q, mem_d;
    logic                        push_ok, pop_ok;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rptr_q];

    // Next storage, pointers (wrapping naturally mod DEPTH) and occupancy
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        cnt_d = cnt_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end

    // FIFO state registers, emptied by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/iob_uart_console_ctrl.sv
// Hardware console sequencer for iob_uart: runs the init writes, then
// round-robins RXREADY/TXREADY polls, moving bytes between the UART and
// local RX/TX FIFOs. Define UART_CONSOLE_CTRL_STATS_EN to add rx_cnt,
// tx_cnt and poll_cnt traffic counters.
module iob_uart_console_ctrl
    import iob_uart_console_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int A_SOFTRST  = A_SOFTRST_DEF,
    parameter int A_DIV      = A_DIV_DEF,
    parameter int A_TXDATA   = A_TXDATA_DEF,
    parameter int A_TXEN     = A_TXEN_DEF,
    parameter int A_TXREADY  = A_TXREADY_DEF,
    parameter int A_RXDATA   = A_RXDATA_DEF,
    parameter int A_RXEN     = A_RXEN_DEF,
    parameter int A_RXREADY  = A_RXREADY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       div,
    output logic              uart_valid,
    output logic [ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0] uart_wdata,
    output logic [3:0]        uart_wstrb,
    input  logic [DATA_W-1:0] uart_rdata,
    input  logic              uart_ready,
    input  logic              tx_valid,
    input  logic [7:0]        tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    input  logic              rx_ready,
`ifdef UART_CONSOLE_CTRL_STATS_EN
    output logic [15:0]       rx_cnt,
    output logic [15:0]       tx_cnt,
    output logic [15:0]       poll_cnt,
`endif
    output logic              init_done
);
    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                init_done_q, init_done_d;
    logic                rr_q, rr_d;      // 0: RX next on contention, 1: TX next

    logic                req_en;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [3:0]          req_wstrb;
    logic                done;
    logic                rx_push, tx_pop, poll_miss;
    logic                rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]          tx_head;
    logic                unused_ok;

    assign done       = valid_q && uart_ready;
    assign uart_valid = valid_q;
    assign uart_addr  = addr_q;
    assign uart_wdata = wdata_q;
    assign uart_wstrb = wstrb_q;
    assign init_done  = init_done_q;
    assign tx_ready   = !tx_full;
    assign rx_valid   = !rx_empty;
    assign unused_ok  = ^{uart_rdata[DATA_W-1:8], poll_miss};

    iob_uart_console_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rx_push),
        .din  (uart_rdata[7:0]),
        .pop  (rx_valid && rx_ready),
        .dout (rx_data),
        .full (rx_full),
        .empty(rx_empty)
    );

    iob_uart_console_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (tx_valid && tx_ready),
        .din  (tx_data),
        .pop  (tx_pop),
        .dout (tx_head),
        .full (tx_full),
        .empty(tx_empty)
    );

    // Sequencer: pick the request for this state, advance on the ready pulse,
    // and only raise a new request from an idle bus (one idle cycle minimum)
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        init_done_d = init_done_q;
        rr_d        = rr_q;
        req_en      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = WSTRB_RD;
        rx_push     = 1'b0;
        tx_pop      = 1'b0;
        poll_miss   = 1'b0;
        unique case (state_q)
            S_SRST: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_SOFTRST);
                req_wdata = DATA_W'(1); req_wstrb = WSTRB_B0;
                if (done) state_d = S_SCLR;
            end
            S_SCLR: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_SOFTRST);
                req_wdata = '0; req_wstrb = WSTRB_B0;
                if (done) state_d = S_DIV;
            end
            S_DIV: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_DIV);
                req_wdata = DATA_W'(div); req_wstrb = WSTRB_H0;
                if (done) state_d = S_TXEN;
            end
            S_TXEN: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_TXEN);
                req_wdata = DATA_W'(1); req_wstrb = WSTRB_B0;
                if (done) state_d = S_RXEN;
            end
            S_RXEN: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_RXEN);
                req_wdata = DATA_W'(1); req_wstrb = WSTRB_B0;
                if (done) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                // RX only polls when there is room, so a received byte always lands
                if (!rx_full && !tx_empty) begin
                    state_d = rr_q ? S_PTX : S_PRX;
                    rr_d    = !rr_q;
                end else if (!rx_full) begin
                    state_d = S_PRX;
                end else if (!tx_empty) begin
                    state_d = S_PTX;
                end
            end
            S_PRX: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_RXREADY);
                if (done) begin
                    state_d   = uart_rdata[0] ? S_RRX : S_IDLE;
                    poll_miss = !uart_rdata[0];
                end
            end
            S_RRX: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_RXDATA);
                if (done) begin
                    rx_push = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PTX: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_TXREADY);
                if (done) begin
                    state_d   = uart_rdata[0] ? S_WTX : S_IDLE;
                    poll_miss = !uart_rdata[0];
                end
            end
            S_WTX: begin
                req_en = 1'b1; req_addr = ADDR_W'(A_TXDATA);
                req_wdata = {{(DATA_W-8){1'b0}}, tx_head}; req_wstrb = WSTRB_B0;
                if (done) begin
                    tx_pop  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_SRST;
        endcase
        if (done) begin
            valid_d = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            wstrb_d = '0;
        end else if (req_en && !valid_q) begin
            valid_d = 1'b1;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wstrb_d = req_wstrb;
        end
    end

    // Sequencer and bus request registers; reset abandons any open request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_SRST;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            init_done_q <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            init_done_q <= init_done_d;
            rr_q        <= rr_d;
        end
    end

`ifdef UART_CONSOLE_CTRL_STATS_EN
    logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, poll_cnt_q, poll_cnt_d;

    assign rx_cnt   = rx_cnt_q;
    assign tx_cnt   = tx_cnt_q;
    assign poll_cnt = poll_cnt_q;

    // Free-running 16-bit event counters
    always_comb begin
        rx_cnt_d   = rx_cnt_q + {15'd0, rx_push};
        tx_cnt_d   = tx_cnt_q + {15'd0, tx_pop};
        poll_cnt_d = poll_cnt_q + {15'd0, poll_miss};
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            poll_cnt_q <= '0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end
`endif

endmodule
